// File: rtl/dpwm_seq_ctrl.sv
// dpwm_seq_ctrl: soft-start / run / stop / fault sequencer producing period-aligned dpwm controls
module dpwm_seq_ctrl #(
    parameter int TS      = 1000,
    parameter int TON_MIN = 20,
    parameter int TON_MAX = 900,
    parameter int SS_STEP = 2,
    parameter int SS_DIV  = 4
) (
    input  logic        i_clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_fault,
    input  logic        i_clear,
    input  logic [10:0] i_ref_ton,
    input  logic        i_ref_valid,
    output logic        o_ref_ready,
    input  logic [4:0]  i_dt1,
    input  logic [4:0]  i_dt2,
    output logic [10:0] o_ton,
    output logic [4:0]  o_dt1,
    output logic [4:0]  o_dt2,
    output logic        o_enable,
    output logic        o_pwm_rst,
    output logic        o_period_last,
    output logic [1:0]  o_state,
    output logic        o_ss_done
);
    typedef enum logic [1:0] {OFF = 2'd0, SOFTSTART = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;
    state_t      state, state_d;
    logic [10:0] count, count_d, target, ton_d, ton_step, ton_ramp, ref_clamped;
    logic [3:0]  ss_cnt, ss_cnt_d;
    logic        active_d, start_ok, ss_wrap;
    if (TON_MAX + 62 >= TS) begin : g_bad_ton_max
        $error("TON_MAX + 62 must be below TS");
    end
    if (SS_DIV < 1 || SS_DIV > 15) begin : g_bad_ss_div
        $error("SS_DIV must be within 1..15");
    end
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) state <= OFF;
        else          state <= state_d;
    end
    // Fault overrides everything; stop and ramp decisions wait for the period boundary.
    always_comb begin
        state_d = state;
        if (i_fault) state_d = FAULT;
        else case (state)
            OFF:       if (i_start && !i_stop) state_d = SOFTSTART;
            SOFTSTART: if (o_period_last) state_d = i_stop ? OFF : (o_ton >= target ? RUN : SOFTSTART);
            RUN:       if (o_period_last && i_stop) state_d = OFF;
            default:   if (i_clear) state_d = OFF;
        endcase
    end
    always_comb begin
        active_d    = state_d == SOFTSTART || state_d == RUN;
        start_ok    = state == OFF && state_d == SOFTSTART;
        ss_wrap     = ss_cnt == 4'(SS_DIV - 1);
        count_d     = (!active_d || o_pwm_rst || o_period_last) ? '0 : count + 11'd1;
        ref_clamped = i_ref_ton < 11'(TON_MIN) ? 11'(TON_MIN) :
                      i_ref_ton > 11'(TON_MAX) ? 11'(TON_MAX) : i_ref_ton;
        ton_step    = o_ton + 11'(SS_STEP);
        ton_ramp    = ton_step > target ? target : ton_step;
        ton_d       = o_ton;
        ss_cnt_d    = ss_cnt;
        if (start_ok) begin
            ton_d    = 11'(TON_MIN);
            ss_cnt_d = '0;
        end else if (o_period_last && active_d) begin
            ton_d    = (state == RUN || o_ton >= target) ? target : (ss_wrap ? ton_ramp : o_ton);
            ss_cnt_d = ss_wrap ? '0 : ss_cnt + 4'd1;
        end
    end
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            o_period_last <= 1'b0;
            o_ton         <= 11'(TON_MIN);
            ss_cnt        <= '0;
            target        <= 11'(TON_MIN);
            o_dt1         <= '0;
            o_dt2         <= '0;
            o_enable      <= 1'b0;
            o_pwm_rst     <= 1'b1;
            o_ref_ready   <= 1'b0;
            o_ss_done     <= 1'b0;
        end else begin
            count         <= count_d;
            o_period_last <= count_d == 11'(TS - 1);
            o_ton         <= ton_d;
            ss_cnt        <= ss_cnt_d;
            if (i_ref_valid && o_ref_ready) target <= ref_clamped;
            if (start_ok) begin
                o_dt1 <= i_dt1;
                o_dt2 <= i_dt2;
            end
            o_enable      <= active_d;
            o_pwm_rst     <= !active_d;
            o_ref_ready   <= active_d;
            o_ss_done     <= state_d == RUN;
        end
    end
    assign o_state = state;
endmodule

// File: tb/tb_dpwm_seq_ctrl.sv
// tb_dpwm_seq_ctrl: randomized bench for dpwm_seq_ctrl against a period-level behavioural model
module tb_dpwm_seq_ctrl;
    // Shortened period so the whole run stays well inside the cycle budget.
    localparam int TS      = 200;
    localparam int TON_MIN = 20;
    localparam int TON_MAX = 120;
    localparam int SS_STEP = 4;
    localparam int SS_DIV  = 3;

    logic        i_clk = 1'b0;
    logic        reset_n, i_start, i_stop, i_fault, i_clear, i_ref_valid;
    logic [10:0] i_ref_ton;
    logic [4:0]  i_dt1, i_dt2;
    logic        o_ref_ready, o_enable, o_pwm_rst, o_period_last, o_ss_done;
    logic [10:0] o_ton;
    logic [4:0]  o_dt1, o_dt2;
    logic [1:0]  o_state;

    int n_cmp = 0;
    int n_err = 0;
    int m_state, m_cnt, m_ton, m_tgt, m_periods, m_dt1, m_dt2;

    dpwm_seq_ctrl #(.TS(TS), .TON_MIN(TON_MIN), .TON_MAX(TON_MAX), .SS_STEP(SS_STEP), .SS_DIV(SS_DIV)) dut (
        .i_clk(i_clk), .reset_n(reset_n), .i_start(i_start), .i_stop(i_stop), .i_fault(i_fault),
        .i_clear(i_clear), .i_ref_ton(i_ref_ton), .i_ref_valid(i_ref_valid), .o_ref_ready(o_ref_ready),
        .i_dt1(i_dt1), .i_dt2(i_dt2), .o_ton(o_ton), .o_dt1(o_dt1), .o_dt2(o_dt2), .o_enable(o_enable),
        .o_pwm_rst(o_pwm_rst), .o_period_last(o_period_last), .o_state(o_state), .o_ss_done(o_ss_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return v < TON_MIN ? TON_MIN : (v > TON_MAX ? TON_MAX : v);
    endfunction

    function automatic void model_reset();
        m_state = 0; m_cnt = 0; m_ton = TON_MIN; m_tgt = TON_MIN; m_periods = 0; m_dt1 = 0; m_dt2 = 0;
    endfunction

    // One clock of the converter sequence, expressed in whole PWM periods and ramp steps.
    function automatic void model_step();
        bit last    = m_cnt == TS - 1;
        bit was_on  = m_state == 1 || m_state == 2;
        int nstate  = m_state;
        int nton    = m_ton;
        int ntgt    = (i_ref_valid && was_on) ? clampv(int'(i_ref_ton)) : m_tgt;
        bit now_on;
        if (i_fault) nstate = 3;
        else if (m_state == 0) begin
            if (i_start && !i_stop) begin
                nstate = 1; nton = TON_MIN; m_periods = 0; m_dt1 = int'(i_dt1); m_dt2 = int'(i_dt2);
            end
        end else if (m_state == 3) begin
            if (i_clear) nstate = 0;
        end else if (last) begin
            if (i_stop) nstate = 0;
            else if (m_state == 2) nton = m_tgt;
            else begin
                m_periods++;
                if (m_ton >= m_tgt) begin nton = m_tgt; nstate = 2; end
                else if (m_periods == SS_DIV) begin
                    m_periods = 0;
                    nton = (m_ton + SS_STEP < m_tgt) ? m_ton + SS_STEP : m_tgt;
                end
            end
        end
        now_on  = nstate == 1 || nstate == 2;
        m_cnt   = (was_on && now_on) ? (m_cnt + 1) % TS : 0;
        m_state = nstate;
        m_ton   = nton;
        m_tgt   = ntgt;
    endfunction

    task automatic check_all();
        bit on = m_state == 1 || m_state == 2;
        chk("state", o_state, m_state);
        chk("ton", o_ton, m_ton);
        chk("dt1", o_dt1, m_dt1);
        chk("dt2", o_dt2, m_dt2);
        chk("enable", o_enable, on);
        chk("pwm_rst", o_pwm_rst, !on);
        chk("ready", o_ref_ready, on);
        chk("ss_done", o_ss_done, m_state == 2);
        chk("period_last", o_period_last, m_cnt == TS - 1);
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (reset_n) model_step();
        else model_reset();
        #1 check_all();
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (int'(o_state) != s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", o_state, s);
    endtask

    task automatic run_to_count(input int c);
        int n = 0;
        while (m_cnt != c && n < 4 * TS) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int refs[4];
        reset_n = 1'b0; i_start = 0; i_stop = 0; i_fault = 0; i_clear = 0;
        i_ref_valid = 0; i_ref_ton = '0; i_dt1 = '0; i_dt2 = '0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Soft-start ramp to 100 with dead times 3/4.
        i_start = 1; i_ref_ton = 11'd100; i_ref_valid = 1; i_dt1 = 5'd3; i_dt2 = 5'd4;
        wait_state(2, 20000);
        chk("ramp_end_ton", o_ton, 100);
        i_start = 0; i_ref_valid = 0;

        // Run-time commands including both clamp limits; dead-time inputs change meanwhile.
        refs = '{60, 1500, 5, 0};
        refs[3] = int'($urandom_range(0, 2047));
        foreach (refs[k]) begin
            run_to_count(TS / 3);
            chk("ready_run", o_ref_ready, 1);
            i_ref_ton = 11'(refs[k]); i_ref_valid = 1; i_dt1 = 5'(17 + k); i_dt2 = 5'(9 + k);
            tick();
            i_ref_valid = 0;
            repeat (TS) tick();
            chk("ref_applied", o_ton, clampv(refs[k]));
        end
        chk("dt1_hold", o_dt1, 3);
        chk("dt2_hold", o_dt2, 4);

        // Stop mid-period completes the period, then holds the counter.
        run_to_count(TS / 2);
        i_stop = 1;
        wait_state(0, 2 * TS);
        i_stop = 0;
        repeat (10) tick();

        // Start with stop is ignored; then fault mid soft-start.
        i_start = 1; i_stop = 1;
        repeat (5) tick();
        chk("start_stop_off", o_state, 0);
        i_stop = 0;
        tick();
        run_to_count(123);
        i_start = 0; i_fault = 1;
        tick();
        chk("fault_state", o_state, 3);
        chk("fault_enable", o_enable, 0);
        i_clear = 1;
        repeat (5) tick();
        chk("clear_ignored", o_state, 3);
        i_fault = 0; i_clear = 0;
        tick();
        i_clear = 1;
        tick();
        i_clear = 0;
        chk("fault_exit", o_state, 0);

        // Randomized traffic over all controls.
        for (int i = 0; i < 15000; i++) begin
            i_start     = ($urandom % 20) == 0;
            i_stop      = (($urandom % 700) == 0) || (i_stop && ($urandom % 40) != 0);
            i_fault     = (($urandom % 3000) == 0) || (i_fault && ($urandom % 10) != 0);
            i_clear     = ($urandom % 30) == 0;
            i_ref_valid = ($urandom % 80) == 0;
            i_ref_ton   = 11'($urandom_range(0, 2047));
            i_dt1       = 5'($urandom);
            i_dt2       = 5'($urandom);
            tick();
        end
        i_start = 0; i_fault = 0; i_ref_valid = 0; i_clear = 1; i_stop = 1;
        wait_state(0, 3 * TS);
        i_clear = 0; i_stop = 0;
        tick();

        // Asynchronous reset in the middle of RUN.
        i_start = 1; i_ref_ton = 11'd60; i_ref_valid = 1;
        wait_state(2, 20000);
        i_start = 0; i_ref_valid = 0;
        run_to_count(TS / 2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", o_state, 0);
        chk("arst_ton", o_ton, TON_MIN);
        chk("arst_dt1", o_dt1, 0);
        chk("arst_dt2", o_dt2, 0);
        chk("arst_enable", o_enable, 0);
        chk("arst_pwm_rst", o_pwm_rst, 1);
        chk("arst_ready", o_ref_ready, 0);
        chk("arst_ss_done", o_ss_done, 0);
        chk("arst_period_last", o_period_last, 0);
        model_reset();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
